// File: rtl/tile_traverser.sv
// Walks a triangle's bounding box in T x T tiles, row-major, with tile-origin edge values and a trivial-reject flag.
// First tile 3 cycles after start; accepted tiles are held until done_in, rejected tiles need no handshake.
module tile_traverser #(
  parameter int COORD_W = 10,
  parameter int COEFF_W = 16,
  parameter int T       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [COORD_W-1:0]          bbox_min_x,
  input  logic [COORD_W-1:0]          bbox_min_y,
  input  logic [COORD_W-1:0]          bbox_max_x,
  input  logic [COORD_W-1:0]          bbox_max_y,
  input  logic signed [COEFF_W-1:0]   a0_in,
  input  logic signed [COEFF_W-1:0]   a1_in,
  input  logic signed [COEFF_W-1:0]   a2_in,
  input  logic signed [COEFF_W-1:0]   b0_in,
  input  logic signed [COEFF_W-1:0]   b1_in,
  input  logic signed [COEFF_W-1:0]   b2_in,
  input  logic signed [2*COEFF_W-1:0] c0_in,
  input  logic signed [2*COEFF_W-1:0] c1_in,
  input  logic signed [2*COEFF_W-1:0] c2_in,
  input  logic                        done_in,
  output logic                        valid_out,
  output logic [COORD_W-1:0]          tile_x,
  output logic [COORD_W-1:0]          tile_y,
  output logic                        tile_inside,
  output logic signed [2*COEFF_W-1:0] e0,
  output logic signed [2*COEFF_W-1:0] e1,
  output logic signed [2*COEFF_W-1:0] e2,
  output logic signed [COEFF_W-1:0]   a0,
  output logic signed [COEFF_W-1:0]   a1,
  output logic signed [COEFF_W-1:0]   a2,
  output logic                        busy,
  output logic                        tri_done
);

  localparam int E_W = 2 * COEFF_W;
  localparam int SH  = $clog2(T);
  localparam logic [COORD_W-1:0]    TILE_MASK = ~COORD_W'(T - 1);
  localparam logic [COORD_W:0]      T_EXT     = (COORD_W + 1)'(T);
  localparam logic signed [E_W-1:0] TM1       = E_W'(T - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EVAL, S_ISSUE, S_WAIT_DONE, S_ADVANCE, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0]        min_x, min_y, max_x, max_y, x_start;
  logic signed [COEFF_W-1:0] a_lat [3];
  logic signed [COEFF_W-1:0] b_lat [3];
  logic signed [E_W-1:0]     c_lat [3];
  logic signed [E_W-1:0]     row_e [3];
  logic signed [E_W-1:0]     cur_e [3];

  logic signed [E_W-1:0] sa [3];
  logic signed [E_W-1:0] sb [3];
  logic signed [E_W-1:0] init_e [3];
  logic signed [E_W-1:0] ex [3];
  logic signed [E_W-1:0] ey [3];
  logic signed [E_W-1:0] exy [3];
  logic [2:0]            edge_ok;
  logic [COORD_W-1:0]    x0, y0;
  logic                  x_fits, y_fits, box_empty;

  always_comb begin
    x0        = min_x & TILE_MASK;
    y0        = min_y & TILE_MASK;
    // One extra bit so a tile step near the top of the coordinate range cannot wrap
    x_fits    = ({1'b0, tile_x} + T_EXT) <= {1'b0, max_x};
    y_fits    = ({1'b0, tile_y} + T_EXT) <= {1'b0, max_y};
    box_empty = (min_x > max_x) || (min_y > max_y);
    edge_ok   = '0;
    for (int k = 0; k < 3; k++) begin
      sa[k]     = {{(E_W-COEFF_W){a_lat[k][COEFF_W-1]}}, a_lat[k]};
      sb[k]     = {{(E_W-COEFF_W){b_lat[k][COEFF_W-1]}}, b_lat[k]};
      init_e[k] = sa[k] * $signed({{(E_W-COORD_W){1'b0}}, x0})
                + sb[k] * $signed({{(E_W-COORD_W){1'b0}}, y0}) + c_lat[k];
      ex[k]     = cur_e[k] + sa[k] * TM1;
      ey[k]     = cur_e[k] + sb[k] * TM1;
      exy[k]    = cur_e[k] + (sa[k] + sb[k]) * TM1;
      // An edge rejects the tile only when all four corners are negative
      edge_ok[k] = ~(cur_e[k][E_W-1] & ex[k][E_W-1] & ey[k][E_W-1] & exy[k][E_W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid_out = 1'b0;
    busy      = 1'b1;
    tri_done  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_SETUP;
      end
      S_SETUP:     state_nxt = box_empty ? S_FINISH : S_EVAL;
      S_EVAL:      state_nxt = S_ISSUE;
      S_ISSUE: begin
        valid_out = 1'b1;
        state_nxt = tile_inside ? S_WAIT_DONE : S_ADVANCE;
      end
      S_WAIT_DONE: if (done_in) state_nxt = S_ADVANCE;
      S_ADVANCE:   state_nxt = (x_fits || y_fits) ? S_EVAL : S_FINISH;
      S_FINISH: begin
        tri_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_x       <= '0;
      min_y       <= '0;
      max_x       <= '0;
      max_y       <= '0;
      x_start     <= '0;
      tile_x      <= '0;
      tile_y      <= '0;
      tile_inside <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        a_lat[k] <= '0;
        b_lat[k] <= '0;
        c_lat[k] <= '0;
        row_e[k] <= '0;
        cur_e[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (start) begin
          min_x    <= bbox_min_x;
          min_y    <= bbox_min_y;
          max_x    <= bbox_max_x;
          max_y    <= bbox_max_y;
          a_lat[0] <= a0_in;
          a_lat[1] <= a1_in;
          a_lat[2] <= a2_in;
          b_lat[0] <= b0_in;
          b_lat[1] <= b1_in;
          b_lat[2] <= b2_in;
          c_lat[0] <= c0_in;
          c_lat[1] <= c1_in;
          c_lat[2] <= c2_in;
        end
        S_SETUP: if (!box_empty) begin
          x_start <= x0;
          tile_x  <= x0;
          tile_y  <= y0;
          for (int k = 0; k < 3; k++) begin
            row_e[k] <= init_e[k];
            cur_e[k] <= init_e[k];
          end
        end
        S_EVAL: tile_inside <= &edge_ok;
        S_ADVANCE: begin
          if (x_fits) begin
            tile_x <= tile_x + COORD_W'(T);
            for (int k = 0; k < 3; k++) cur_e[k] <= cur_e[k] + (sa[k] <<< SH);
          end else if (y_fits) begin
            tile_x <= x_start;
            tile_y <= tile_y + COORD_W'(T);
            for (int k = 0; k < 3; k++) begin
              row_e[k] <= row_e[k] + (sb[k] <<< SH);
              cur_e[k] <= row_e[k] + (sb[k] <<< SH);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign e0 = cur_e[0];
  assign e1 = cur_e[1];
  assign e2 = cur_e[2];
  assign a0 = a_lat[0];
  assign a1 = a_lat[1];
  assign a2 = a_lat[2];

endmodule

// File: tb/tb_tile_traverser.sv
// Bench for tile_traverser: directed and random triangles against a direct-evaluation tile list model.
module tb_tile_traverser;

  logic clk = 1'b0;
  logic rst, start, done_in;
  logic [9:0] bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y;
  logic signed [15:0] a0_in, a1_in, a2_in, b0_in, b1_in, b2_in;
  logic signed [31:0] c0_in, c1_in, c2_in;
  logic valid_out, tile_inside, busy, tri_done;
  logic [9:0] tile_x, tile_y;
  logic signed [31:0] e0, e1, e2;
  logic signed [15:0] a0, a1, a2;

  always #5 clk = ~clk;

  tile_traverser dut (
    .clk(clk), .rst(rst), .start(start),
    .bbox_min_x(bbox_min_x), .bbox_min_y(bbox_min_y),
    .bbox_max_x(bbox_max_x), .bbox_max_y(bbox_max_y),
    .a0_in(a0_in), .a1_in(a1_in), .a2_in(a2_in),
    .b0_in(b0_in), .b1_in(b1_in), .b2_in(b2_in),
    .c0_in(c0_in), .c1_in(c1_in), .c2_in(c2_in),
    .done_in(done_in), .valid_out(valid_out),
    .tile_x(tile_x), .tile_y(tile_y), .tile_inside(tile_inside),
    .e0(e0), .e1(e1), .e2(e2), .a0(a0), .a1(a1), .a2(a2),
    .busy(busy), .tri_done(tri_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int e[3];
    bit ins;
  } tile_t;

  int mnx, mny, mxx, mxy;
  int ca[3], cb[3], cc[3];
  tile_t exp_q[$];

  // Edge function evaluated directly at a pixel, wrapping in 32 bits
  function automatic int ev(int k, int x, int y);
    return ca[k] * x + cb[k] * y + cc[k];
  endfunction

  function automatic void build_model();
    tile_t t;
    exp_q.delete();
    if (mnx > mxx || mny > mxy) return;
    for (int ty = mny & ~15; ty <= mxy; ty += 16)
      for (int tx = mnx & ~15; tx <= mxx; tx += 16) begin
        t.x = tx;
        t.y = ty;
        t.ins = 1'b1;
        for (int k = 0; k < 3; k++) begin
          t.e[k] = ev(k, tx, ty);
          if (ev(k, tx, ty) < 0 && ev(k, tx + 15, ty) < 0 &&
              ev(k, tx, ty + 15) < 0 && ev(k, tx + 15, ty + 15) < 0)
            t.ins = 1'b0;
        end
        exp_q.push_back(t);
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tri();
    bbox_min_x = mnx[9:0]; bbox_min_y = mny[9:0];
    bbox_max_x = mxx[9:0]; bbox_max_y = mxy[9:0];
    a0_in = ca[0][15:0]; a1_in = ca[1][15:0]; a2_in = ca[2][15:0];
    b0_in = cb[0][15:0]; b1_in = cb[1][15:0]; b2_in = cb[2][15:0];
    c0_in = cc[0]; c1_in = cc[1]; c2_in = cc[2];
  endtask

  task automatic scramble_inputs();
    bbox_min_x = 10'($urandom); bbox_max_x = 10'($urandom);
    bbox_min_y = 10'($urandom); bbox_max_y = 10'($urandom);
    a0_in = 16'($urandom); a1_in = 16'($urandom); a2_in = 16'($urandom);
    b0_in = 16'($urandom); b1_in = 16'($urandom); b2_in = 16'($urandom);
    c0_in = $urandom; c1_in = $urandom; c2_in = $urandom;
  endtask

  // noise: pulse start and done_in in EVAL, done_in in ISSUE; all must be ignored
  task automatic run_tri(input bit noise);
    tile_t t;
    int gap;
    int d;
    build_model();
    drive_tri();
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
    gap = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      t = exp_q[i];
      while (!valid_out && gap < 8) begin
        start   = noise && gap == 2;
        done_in = noise && gap == 2;
        tick();
        gap++;
        start   = 1'b0;
        done_in = 1'b0;
      end
      chk("tile_gap", gap, 3);
      chk("tile_x", tile_x, t.x);
      chk("tile_y", tile_y, t.y);
      chk("e0", e0, t.e[0]);
      chk("e1", e1, t.e[1]);
      chk("e2", e2, t.e[2]);
      chk("inside", tile_inside, t.ins);
      chk("busy", busy, 1);
      chk("a0", a0, ca[0]);
      chk("a2", a2, ca[2]);
      done_in = noise;
      tick();
      done_in = 1'b0;
      if (t.ins) begin
        d = $urandom_range(0, 3);
        repeat (d) begin
          chk("hold_vld", valid_out, 0);
          chk("hold_x", tile_x, t.x);
          chk("hold_e0", e0, t.e[0]);
          tick();
        end
        chk("hold_y", tile_y, t.y);
        chk("hold_ins", tile_inside, 1);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
      end
      gap = 1;
    end
    while (!tri_done && !valid_out && gap < 8) begin
      tick();
      gap++;
    end
    chk("fin_gap", gap, 2);
    chk("fin_pulse", tri_done, 1);
    chk("fin_vld", valid_out, 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", tri_done, 0);
  endtask

  task automatic set_flat(input int c0, input int c1, input int c2);
    for (int k = 0; k < 3; k++) begin
      ca[k] = 0;
      cb[k] = 0;
    end
    cc[0] = c0; cc[1] = c1; cc[2] = c2;
  endtask

  task automatic set_box(input int x0, input int y0, input int x1, input int y1);
    mnx = x0; mny = y0; mxx = x1; mxy = y1;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; done_in = 1'b0;
    scramble_inputs();
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_vld", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", tile_x, 0);
    chk("rst_e0", e0, 0);
    chk("rst_ins", tile_inside, 0);
    chk("rst_done", tri_done, 0);

    set_flat(5, 5, 5);      set_box(3, 2, 40, 20);    run_tri(1'b0);
    set_flat(-1, 5, 5);     set_box(3, 2, 40, 20);    run_tri(1'b0);
    set_flat(-40, 100, 100); ca[0] = 1; cb[0] = 2;
    set_box(0, 0, 31, 31);  run_tri(1'b0);
    set_flat(5, 5, 5);      set_box(20, 0, 10, 5);    run_tri(1'b0);
    set_flat(1, 1, 1);      set_box(1000, 1000, 1023, 1023); run_tri(1'b0);
    set_flat(5, 5, 5);      set_box(3, 2, 40, 20);    run_tri(1'b1);
    set_flat(-40, 100, 100); ca[0] = 1; cb[0] = 2;
    set_box(0, 0, 31, 31);  run_tri(1'b1);

    // Abort mid-walk from WAIT_DONE, then a fresh triangle must start cleanly
    set_flat(7, 7, 7); ca[1] = -3; set_box(3, 2, 40, 20);
    drive_tri();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!valid_out && n < 8) begin
      tick();
      n++;
    end
    chk("pre_rst_gap", n, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_vld", valid_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_x", tile_x, 0);
    chk("abort_e0", e0, 0);
    chk("abort_a1", a1, 0);
    chk("abort_ins", tile_inside, 0);
    set_flat(5, 5, 5); set_box(3, 2, 40, 20); run_tri(1'b0);

    for (int r = 0; r < 30; r++) begin
      mnx = $urandom_range(0, 1000);
      mny = $urandom_range(0, 1000);
      mxx = mnx + $urandom_range(0, 80);
      mxy = mny + $urandom_range(0, 80);
      if (mxx > 1023) mxx = 1023;
      if (mxy > 1023) mxy = 1023;
      if ($urandom_range(0, 7) == 0 && mnx > 0) mxx = mnx - 1;
      for (int k = 0; k < 3; k++) begin
        if (r % 2 == 0) begin
          ca[k] = int'($urandom_range(0, 65535)) - 32768;
          cb[k] = int'($urandom_range(0, 65535)) - 32768;
          cc[k] = int'($urandom);
        end else begin
          ca[k] = int'($urandom_range(0, 400)) - 200;
          cb[k] = int'($urandom_range(0, 400)) - 200;
          cc[k] = int'($urandom_range(0, 400000)) - 200000;
        end
      end
      run_tri(r % 3 == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
